// File: rtl/eth_header_pkg.sv
// Shared types and constants for the byte-serial Ethernet header parser.
package eth_header_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DST,
        ST_SRC,
        ST_TL
    } state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [2:0] PREAMBLE_LEN  = 3'd7;
    localparam logic [2:0] MAC_LEN       = 3'd6;
    localparam logic [2:0] TL_LEN        = 3'd2;

endpackage

// File: rtl/eth_header_fsm.sv
// Byte-serial Ethernet header parser: hunts for preamble+SFD, then captures
// DST MAC, SRC MAC and Type/Length, strobing once per completed field.
module eth_header_fsm
    import eth_header_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic        preamble_valid,
    output logic        dst_addr_valid,
    output logic        src_addr_valid,
    output logic        type_length_valid,
    output logic [47:0] dst_addr,
    output logic [47:0] src_addr,
    output logic [15:0] type_length
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [47:0] shift_q, shift_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [15:0] tl_q, tl_d;
    logic        pv_q, pv_d;
    logic        dv_q, dv_d;
    logic        sv_q, sv_d;
    logic        tv_q, tv_d;

    // State, counter, shift register and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            tl_q    <= '0;
            pv_q    <= 1'b0;
            dv_q    <= 1'b0;
            sv_q    <= 1'b0;
            tv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            tl_q    <= tl_d;
            pv_q    <= pv_d;
            dv_q    <= dv_d;
            sv_q    <= sv_d;
            tv_q    <= tv_d;
        end
    end

    // Next-state, field capture and strobe generation; nothing moves unless enable.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dst_d   = dst_q;
        src_d   = src_q;
        tl_d    = tl_q;
        pv_d    = 1'b0;
        dv_d    = 1'b0;
        sv_d    = 1'b0;
        tv_d    = 1'b0;
        if (enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    // Unknown data compares false and keeps us hunting.
                    if (data == PREAMBLE_BYTE) begin
                        state_d = ST_PREAMBLE;
                        cnt_d   = 3'd1;
                    end
                end
                ST_PREAMBLE: begin
                    if (data == PREAMBLE_BYTE) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == PREAMBLE_LEN - 3'd1) state_d = ST_SFD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_SFD: begin
                    // Extra preamble octets are tolerated while waiting for SFD.
                    if (data == SFD_BYTE) begin
                        state_d = ST_DST;
                        cnt_d   = '0;
                        pv_d    = 1'b1;
                    end else if (data != PREAMBLE_BYTE) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_DST: begin
                    shift_d = {shift_q[39:0], data};
                    if (cnt_q == MAC_LEN - 3'd1) begin
                        dst_d   = shift_d;
                        dv_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_SRC;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_SRC: begin
                    shift_d = {shift_q[39:0], data};
                    if (cnt_q == MAC_LEN - 3'd1) begin
                        src_d   = shift_d;
                        sv_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_TL;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_TL: begin
                    shift_d = {shift_q[39:0], data};
                    if (cnt_q == TL_LEN - 3'd1) begin
                        tl_d    = shift_d[15:0];
                        tv_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign preamble_valid    = pv_q;
    assign dst_addr_valid    = dv_q;
    assign src_addr_valid    = sv_q;
    assign type_length_valid = tv_q;
    assign dst_addr          = dst_q;
    assign src_addr          = src_q;
    assign type_length       = tl_q;

endmodule

// File: tb/tb_eth_header_fsm.sv
// Directed bench for eth_header_fsm: frames are pushed one byte per step and
// every step checks the four strobes, so any timing shift is caught.
module tb_eth_header_fsm;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  data;
    logic        preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid;
    logic [47:0] dst_addr, src_addr;
    logic [15:0] type_length;

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] NOM_DST = 48'h010203040506;
    localparam logic [47:0] NOM_SRC = 48'hFFFEFDFCFBFA;
    localparam logic [15:0] NOM_TL  = 16'h0800;

    eth_header_fsm dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .data              (data),
        .preamble_valid    (preamble_valid),
        .dst_addr_valid    (dst_addr_valid),
        .src_addr_valid    (src_addr_valid),
        .type_length_valid (type_length_valid),
        .dst_addr          (dst_addr),
        .src_addr          (src_addr),
        .type_length       (type_length)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte, let one rising edge sample it, settle 1 time unit after.
    task automatic step(input logic en, input logic [7:0] b);
        enable = en;
        data   = b;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_strobes(input string tag, input logic [3:0] exp);
        chk(tag, {60'd0, preamble_valid, dst_addr_valid, src_addr_valid, type_length_valid},
            {60'd0, exp});
    endtask

    // Full frame; gap inserts 3 disabled cycles after the 2nd SRC byte.
    task automatic send_frame(input string tag, input int npre, input logic [47:0] d,
                              input logic [47:0] s, input logic [15:0] t, input bit gap);
        for (int i = 0; i < npre; i++) begin
            step(1'b1, 8'h55);
            chk_strobes({tag, ".pre"}, 4'b0000);
        end
        step(1'b1, 8'hD5);
        chk_strobes({tag, ".sfd"}, 4'b1000);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, d[47-8*i -: 8]);
            chk_strobes({tag, ".dst"}, (i == 5) ? 4'b0100 : 4'b0000);
        end
        chk({tag, ".dst_addr"}, {16'd0, dst_addr}, {16'd0, d});
        for (int i = 0; i < 6; i++) begin
            if (gap && i == 2) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 8'hD5);
                    chk_strobes({tag, ".gap"}, 4'b0000);
                end
            end
            step(1'b1, s[47-8*i -: 8]);
            chk_strobes({tag, ".src"}, (i == 5) ? 4'b0010 : 4'b0000);
        end
        chk({tag, ".src_addr"}, {16'd0, src_addr}, {16'd0, s});
        step(1'b1, t[15:8]);
        chk_strobes({tag, ".tl0"}, 4'b0000);
        step(1'b1, t[7:0]);
        chk_strobes({tag, ".tl1"}, 4'b0001);
        chk({tag, ".type_length"}, {48'd0, type_length}, {48'd0, t});
        chk({tag, ".dst_hold"}, {16'd0, dst_addr}, {16'd0, d});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".strobes"}, {60'd0, preamble_valid, dst_addr_valid, src_addr_valid,
            type_length_valid}, 64'd0);
        chk({tag, ".dst"}, {16'd0, dst_addr}, 64'd0);
        chk({tag, ".src"}, {16'd0, src_addr}, 64'd0);
        chk({tag, ".tl"}, {48'd0, type_length}, 64'd0);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        data   = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        #1;

        // Unknown and junk bytes in IDLE must not start anything.
        step(1'b1, 8'hxx);
        chk_strobes("idle_x", 4'b0000);
        step(1'b1, 8'hD5);
        chk_strobes("idle_d5", 4'b0000);

        // Nominal frame.
        send_frame("nominal", 7, NOM_DST, NOM_SRC, NOM_TL, 1'b0);

        // Short preamble: SFD after 5 x 0x55 is rejected, then a good frame.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h55);
            chk_strobes("short_pre", 4'b0000);
        end
        step(1'b1, 8'hD5);
        chk_strobes("short_sfd", 4'b0000);
        // A few arbitrary bytes: must still be idle (no address capture).
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        chk_strobes("short_after", 4'b0000);
        send_frame("after_bad", 7, 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0806, 1'b0);

        // Bad SFD byte after a full preamble.
        for (int i = 0; i < 7; i++) step(1'b1, 8'h55);
        step(1'b1, 8'h12);
        chk_strobes("bad_sfd", 4'b0000);
        step(1'b1, 8'hD5);
        chk_strobes("bad_sfd_d5", 4'b0000);

        // Long preamble.
        send_frame("long_pre", 10, NOM_DST, NOM_SRC, NOM_TL, 1'b0);

        // Enable gap inside SRC.
        send_frame("gap", 7, 48'h0A0B0C0D0E0F, 48'h102030405060, 16'h86DD, 1'b1);

        // Reset mid-DST: outputs clear without a clock edge.
        for (int i = 0; i < 7; i++) step(1'b1, 8'h55);
        step(1'b1, 8'hD5);
        step(1'b1, 8'h77);
        step(1'b1, 8'h88);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_all_zero("post_rst");
        send_frame("after_rst", 7, NOM_DST, NOM_SRC, NOM_TL, 1'b0);

        // Back-to-back gapless frames; second overwrites first.
        send_frame("b2b_a", 7, 48'h112233445566, 48'hA0A1A2A3A4A5, 16'h88CC, 1'b0);
        send_frame("b2b_b", 7, NOM_DST, NOM_SRC, NOM_TL, 1'b0);
        step(1'b1, 8'h00);
        chk_strobes("b2b_tail", 4'b0000);
        chk("b2b_src_final", {16'd0, src_addr}, {16'd0, NOM_SRC});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_header_fsm.md
# eth_header_fsm

Byte-serial Ethernet header parser. Consumes one octet per enabled clock from the receive byte stream, locks onto a 7-byte preamble plus SFD, then delineates destination MAC, source MAC and Type/Length. Emits a one-cycle valid strobe per completed field and holds the captured field values for downstream frame-filtering and classification logic.

## Interface
Parameters: none; field lengths are package constants.

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears all state and outputs
- `enable`  in  1  byte qualifier; `data` is consumed only on cycles where `enable`=1
- `data`  in  8  receive octet
- `preamble_valid`  out  1  one-cycle strobe: preamble+SFD accepted
- `dst_addr_valid`  out  1  one-cycle strobe: 6 DST bytes captured
- `src_addr_valid`  out  1  one-cycle strobe: 6 SRC bytes captured
- `type_length_valid`  out  1  one-cycle strobe: 2 Type/Length bytes captured
- `dst_addr`  out  48  captured destination MAC; first byte in [47:40]
- `src_addr`  out  48  captured source MAC; first byte in [47:40]
- `type_length`  out  16  captured Type/Length; first byte in [15:8]

## Operation
- States: IDLE, PREAMBLE, SFD, DST, SRC, TL. A byte counter tracks position within the current field.
- IDLE: 0x55 -> PREAMBLE with count=1. Any other byte (including X/unknown) stays in IDLE.
- PREAMBLE: 0x55 increments count; at count=7 -> SFD. A non-0x55 byte -> IDLE, count=0. This includes 0xD5 arriving before seven 0x55 bytes.
- SFD: 0xD5 -> DST, pulse `preamble_valid`. 0x55 stays in SFD, so longer preambles are tolerated. Any other byte -> IDLE.
- DST: shift each byte into the DST shift register, MSB first. On the 6th byte, load `dst_addr`, pulse `dst_addr_valid`, -> SRC.
- SRC: same as DST for 6 bytes. Loads `src_addr`, pulses `src_addr_valid`, -> TL.
- TL: 2 bytes. Loads `type_length`, pulses `type_length_valid`, -> IDLE to hunt for the next frame. Payload bytes are not parsed.
- `enable`=0: state, counter and shift registers hold; no byte is consumed; all strobes are 0.
- There is no in-field error detection after SFD. Any byte value is accepted as address or Type/Length data.

## Timing
- One byte per enabled clock; no back-pressure.
- All outputs are registered. A strobe is high for exactly the one cycle following the rising edge that sampled the last byte of its field.
- `dst_addr`, `src_addr` and `type_length` update on the same edge that raises their strobe. They hold until the next frame overwrites them.
- Gapless frame, first 0x55 sampled on edge N:
  - `preamble_valid` high in cycle N+8 (after edge N+7)
  - `dst_addr_valid` high in cycle N+14
  - `src_addr_valid` high in cycle N+20
  - `type_length_valid` high in cycle N+22
- Reset, asserted at any time including mid-frame: state=IDLE, counter=0, all strobes 0, all captured fields 0. Takes effect immediately, without waiting for a clock edge.
- First enabled byte after reset release is evaluated in IDLE.
- Minimum gap between a `type_length_valid` strobe and the next `preamble_valid` strobe is 8 enabled bytes.

## Structure
- Package `eth_header_pkg`: state enum; constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, PREAMBLE_LEN=7, MAC_LEN=6, TL_LEN=2.
- Single module, no sub-modules: one FSM, one 3-bit counter, one 48-bit shift register shared by all fields, and output registers.

## Test plan
- Nominal frame: 7×0x55, 0xD5, DST 01..06, SRC FF,FE,FD,FC,FB,FA, TL 08,00.
  - Strobes appear in order, one cycle each, at N+8/N+14/N+20/N+22.
  - Captured values: dst_addr=48'h010203040506, src_addr=48'hFFFEFDFCFBFA, type_length=16'h0800.
- Bad preamble:
  - 5×0x55 then 0xD5 -> no strobes; FSM returns to IDLE.
  - A following full nominal frame parses correctly.
- Long preamble: 10×0x55 then 0xD5 plus the nominal fields -> parsed identically to the nominal frame.
- Enable gaps: nominal frame with `enable` deasserted for 3 cycles inside SRC -> strobes delayed by 3 cycles; captured values unchanged.
- Reset mid-frame: assert `reset` during DST -> all outputs 0 immediately. The next nominal frame parses correctly with no stale strobes.
- Back-to-back frames: two nominal frames with different addresses -> second frame's values overwrite the first; two full strobe sequences.
